// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
//
// Round-robin arbiter and sequencer that lets N_REQ cores share one 8-bit ADD
// unit. The winner's operands are captured on the grant edge and driven to
// the adder for one EXEC cycle. The adder's result and flags are then
// registered and held for the winner until it acknowledges them.
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   req         in   N_REQ    per-requester add request
//   op_a        in   8*N_REQ  packed operand A, requester i at [8i+7:8i]
//   op_b        in   8*N_REQ  packed operand B, same packing as op_a
//   gnt         out  N_REQ    one-hot grant, high for the EXEC cycle only
//   add_a       out  8        operand A to the shared ADD
//   add_b       out  8        operand B to the shared ADD
//   add_result  in   8        combinational sum from the shared ADD
//   add_flags   in   4        ADD status: [0]=Z [1]=S [2]=C [3]=V
//   rsp_valid   out  N_REQ    one-hot response valid
//   rsp_result  out  8        registered sum
//   rsp_flags   out  4        registered flags, same layout as add_flags
//   rsp_ack     in   N_REQ    per-requester response acknowledge
//   busy        out  1        high whenever a transaction is in flight
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module add_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] op_a,
    input  logic [8*N_REQ-1:0] op_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    input  logic [7:0]         add_result,
    input  logic [3:0]         add_flags,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_result,
    output logic [3:0]         rsp_flags,
    input  logic [N_REQ-1:0]   rsp_ack,
    output logic               busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [IDX_W-1:0]   last_q,       last_d;     // lowest-priority requester
    logic [IDX_W-1:0]   win_q,        win_d;      // requester being served
    logic [N_REQ-1:0]   gnt_q,        gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q,  rsp_valid_d;
    logic [7:0]         add_a_q,      add_a_d;
    logic [7:0]         add_b_q,      add_b_d;
    logic [7:0]         result_q,     result_d;
    logic [3:0]         flags_q,      flags_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: scan from last_q+1 upward with wrap-around, so the
    // previous winner is considered last. Only consumed in IDLE.
    // -------------------------------------------------------------------------
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every variable written in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_q) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath load logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        rsp_valid_d = rsp_valid_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        result_d    = result_q;
        flags_d     = flags_q;

        unique case (state_q)
            S_IDLE: begin
                // Operands are captured here, so anything the requester does
                // to req/op_* during EXEC cannot disturb the add.
                if (pick_found) begin
                    win_d           = pick_idx;
                    add_a_d         = op_a[8*pick_idx +: 8];
                    add_b_d         = op_b[8*pick_idx +: 8];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = S_EXEC;
                end
            end

            S_EXEC: begin
                // The adder is combinational; its output has settled on
                // add_a_q/add_b_q by the end of this single cycle.
                result_d           = add_result;
                flags_d            = add_flags;
                rsp_valid_d        = '0;
                rsp_valid_d[win_q] = 1'b1;
                gnt_d              = '0;
                state_d            = S_RESP;
            end

            S_RESP: begin
                // Only the winner's ack closes the transaction. The return to
                // IDLE takes a full cycle, so a req seen on this same edge is
                // arbitrated on the next one with last_q already updated.
                if (rsp_ack[win_q]) begin
                    rsp_valid_d = '0;
                    last_d      = win_q;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                rsp_valid_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= IDX_W'(N_REQ - 1);   // requester 0 wins first
            win_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other register.
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_arbiter
//
// Self-checking bench for add_arbiter (N_REQ=4). Provides the shared ADD as a
// combinational model, runs a table of single-requester transactions,
// hand-written multi-cycle sequences (round robin, held response, mid-
// transaction reset, priority rotation), then randomized traffic compared
// cycle by cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_add_arbiter;

    localparam int N   = 4;
    localparam int OPW = 8 * N;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic [N-1:0]   gnt;
    logic [7:0]     add_a;
    logic [7:0]     add_b;
    logic [7:0]     add_result;
    logic [3:0]     add_flags;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_result;
    logic [3:0]     rsp_flags;
    logic [N-1:0]   rsp_ack;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    add_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_flags  (add_flags),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_ack    (rsp_ack),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit add with Z/S/C/V flags computed from plain arithmetic.
    function automatic logic [11:0] add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [3:0] f;
        s    = {1'b0, a} + {1'b0, b};
        f[0] = (s[7:0] == 8'h00);
        f[1] = s[7];
        f[2] = s[8];
        f[3] = (a[7] == b[7]) && (s[7] != a[7]);
        return {s[7:0], f};
    endfunction

    // Shared ADD unit seen by the arbiter.
    always_comb {add_result, add_flags} = add8(add_a, add_b);

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        rsp_ack = '0;
        op_a    = '0;
        op_b    = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Transaction-level reference model for the random phase
    // -------------------------------------------------------------------------
    bit         m_act;
    int         m_stage;    // 0: add in progress, 1: response outstanding
    int         m_w;
    int         m_last;
    logic [7:0] m_a, m_b, m_res;
    logic [3:0] m_flg;

    task automatic model_reset();
        m_act   = 1'b0;
        m_stage = 0;
        m_w     = 0;
        m_last  = N - 1;
        m_a     = '0;
        m_b     = '0;
        m_res   = '0;
        m_flg   = '0;
    endtask

    // Apply the inputs that will be sampled on the coming edge.
    task automatic model_step(input logic [N-1:0] r, input logic [OPW-1:0] a,
                              input logic [OPW-1:0] b, input logic [N-1:0] ack);
        if (!m_act) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!m_act && r[c]) begin
                    m_act   = 1'b1;
                    m_stage = 0;
                    m_w     = c;
                    m_a     = a[8*c +: 8];
                    m_b     = b[8*c +: 8];
                end
            end
        end else if (m_stage == 0) begin
            {m_res, m_flg} = add8(m_a, m_b);
            m_stage        = 1;
        end else if (ack[m_w]) begin
            m_act  = 1'b0;
            m_last = m_w;
        end
    endtask

    // -------------------------------------------------------------------------
    // Table of single-requester transactions
    // -------------------------------------------------------------------------
    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic [3:0] exp_flg;   // {V,C,S,Z}
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h7F, 8'h01, 8'h80, 4'b1010};
        vecs[1] = '{0, 8'hFF, 8'h01, 8'h00, 4'b0101};
        vecs[2] = '{1, 8'h80, 8'h80, 8'h00, 4'b1101};
        vecs[3] = '{2, 8'h12, 8'h34, 8'h46, 4'b0000};
        vecs[4] = '{3, 8'h40, 8'h40, 8'h80, 4'b1010};
        vecs[5] = '{1, 8'hF0, 8'hF0, 8'hE0, 4'b0110};
        vecs[6] = '{2, 8'h00, 8'h00, 8'h00, 4'b0001};
        vecs[7] = '{3, 8'hFF, 8'hFF, 8'hFE, 4'b0110};

        // ---------------- reset state ----------------
        do_reset();
        check("reset gnt",        32'(gnt),        32'h0);
        check("reset rsp_valid",  32'(rsp_valid),  32'h0);
        check("reset add_a",      32'(add_a),      32'h0);
        check("reset add_b",      32'(add_b),      32'h0);
        check("reset rsp_result", 32'(rsp_result), 32'h0);
        check("reset rsp_flags",  32'(rsp_flags),  32'h0);
        check("reset busy",       32'(busy),       32'h0);

        // ---------------- table-driven transactions ----------------
        foreach (vecs[i]) begin
            op_a = OPW'($urandom);
            op_b = OPW'($urandom);
            op_a[8*vecs[i].idx +: 8] = vecs[i].a;
            op_b[8*vecs[i].idx +: 8] = vecs[i].b;
            req = oh(vecs[i].idx);
            tick();                                   // grant edge
            check($sformatf("v%0d gnt", i),       32'(gnt),       32'(oh(vecs[i].idx)));
            check($sformatf("v%0d busy", i),      32'(busy),      32'h1);
            check($sformatf("v%0d add_a", i),     32'(add_a),     32'(vecs[i].a));
            check($sformatf("v%0d add_b", i),     32'(add_b),     32'(vecs[i].b));
            check($sformatf("v%0d early rv", i),  32'(rsp_valid), 32'h0);
            req  = '0;
            op_a = OPW'($urandom);                    // ignored during EXEC
            op_b = OPW'($urandom);
            tick();                                   // end of EXEC
            check($sformatf("v%0d gnt off", i),   32'(gnt),        32'h0);
            check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid),  32'(oh(vecs[i].idx)));
            check($sformatf("v%0d result", i),    32'(rsp_result), 32'(vecs[i].exp_res));
            check($sformatf("v%0d flags", i),     32'(rsp_flags),  32'(vecs[i].exp_flg));
            check($sformatf("v%0d resp busy", i), 32'(busy),       32'h1);
            rsp_ack = oh(vecs[i].idx);
            tick();                                   // ack edge
            rsp_ack = '0;
            check($sformatf("v%0d rv clear", i),  32'(rsp_valid), 32'h0);
            check($sformatf("v%0d idle busy", i), 32'(busy),      32'h0);
        end

        // ---------------- round robin, all requesting, immediate ack ----------------
        do_reset();
        op_a = {8'hF0, 8'h30, 8'h20, 8'h10};
        op_b = {8'h20, 8'h04, 8'h03, 8'h02};
        req  = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            int         w;
            logic [7:0] er;
            logic [3:0] ef;
            w        = j % N;
            {er, ef} = add8(op_a[8*w +: 8], op_b[8*w +: 8]);
            tick();
            check($sformatf("rr%0d gnt", j),   32'(gnt),   32'(oh(w)));
            check($sformatf("rr%0d add_a", j), 32'(add_a), 32'(op_a[8*w +: 8]));
            tick();
            check($sformatf("rr%0d rv", j),     32'(rsp_valid),  32'(oh(w)));
            check($sformatf("rr%0d result", j), 32'(rsp_result), 32'(er));
            check($sformatf("rr%0d flags", j),  32'(rsp_flags),  32'(ef));
            rsp_ack = oh(w);
            tick();
            rsp_ack = '0;
            check($sformatf("rr%0d idle gnt", j), 32'(gnt),       32'h0);
            check($sformatf("rr%0d idle rv", j),  32'(rsp_valid), 32'h0);
            check($sformatf("rr%0d idle busy", j), 32'(busy),     32'h0);
        end
        req = '0;

        // ---------------- held response, wrong-index ack ----------------
        op_a = {8'h00, 8'h00, 8'h00, 8'h55};
        op_b = {8'h00, 8'h00, 8'h00, 8'h22};
        req  = 4'b0001;
        tick();
        check("hold gnt", 32'(gnt), 32'h1);
        req = 4'b0010;                                // must not be granted during RESP
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d rv", c),     32'(rsp_valid),  32'h1);
            check($sformatf("hold%0d result", c), 32'(rsp_result), 32'h77);
            check($sformatf("hold%0d flags", c),  32'(rsp_flags),  32'h0);
            check($sformatf("hold%0d gnt", c),    32'(gnt),        32'h0);
            check($sformatf("hold%0d busy", c),   32'(busy),       32'h1);
            rsp_ack = (c == 2) ? 4'b0100 : 4'b0000;
            tick();
        end
        check("hold wrong ack rv", 32'(rsp_valid), 32'h1);
        rsp_ack = 4'b0001;
        tick();
        rsp_ack = '0;
        check("hold ack rv",   32'(rsp_valid), 32'h0);
        check("hold ack busy", 32'(busy),      32'h0);
        check("hold ack gnt",  32'(gnt),       32'h0);   // req on ack edge waits
        tick();
        check("post ack gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        rsp_ack = 4'b0010;
        tick();
        rsp_ack = '0;

        // ---------------- rotation: 1 just served, then 3 before 1 ----------------
        req = 4'b1010;
        tick();
        check("rot gnt3", 32'(gnt), 32'h8);
        req = 4'b0010;
        tick();
        rsp_ack = 4'b1000;
        tick();
        rsp_ack = '0;
        tick();
        check("rot gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick();
        rsp_ack = 4'b0010;
        tick();
        rsp_ack = '0;

        // ---------------- asynchronous reset during EXEC ----------------
        op_a = {8'hAA, 8'h00, 8'h00, 8'h11};
        op_b = {8'hBB, 8'h00, 8'h00, 8'h22};
        req  = 4'b1000;
        tick();
        check("arst pre gnt", 32'(gnt), 32'h8);
        req = '0;
        #2;
        rst_n = 1'b0;
        #1;                                           // no clock edge in between
        check("arst gnt",        32'(gnt),        32'h0);
        check("arst rsp_valid",  32'(rsp_valid),  32'h0);
        check("arst add_a",      32'(add_a),      32'h0);
        check("arst add_b",      32'(add_b),      32'h0);
        check("arst rsp_result", 32'(rsp_result), 32'h0);
        check("arst rsp_flags",  32'(rsp_flags),  32'h0);
        check("arst busy",       32'(busy),       32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst no rsp a", 32'(rsp_valid), 32'h0);
        tick();
        check("arst no rsp b", 32'(rsp_valid), 32'h0);
        req = 4'b0101;
        tick();
        check("arst regrant", 32'(gnt),   32'h1);
        check("arst add_a2",  32'(add_a), 32'h11);
        req = '0;
        tick();
        rsp_ack = 4'b0001;
        tick();
        rsp_ack = '0;

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] eg, ev;
            req     = N'($urandom) & N'($urandom_range(0, 15));
            op_a    = OPW'($urandom);
            op_b    = OPW'($urandom);
            rsp_ack = N'($urandom);
            model_step(req, op_a, op_b, rsp_ack);
            tick();
            eg = (m_act && m_stage == 0) ? oh(m_w) : '0;
            ev = (m_act && m_stage == 1) ? oh(m_w) : '0;
            check($sformatf("rnd%0d gnt", c),    32'(gnt),        32'(eg));
            check($sformatf("rnd%0d rv", c),     32'(rsp_valid),  32'(ev));
            check($sformatf("rnd%0d busy", c),   32'(busy),       32'(m_act));
            check($sformatf("rnd%0d add_a", c),  32'(add_a),      32'(m_a));
            check($sformatf("rnd%0d add_b", c),  32'(add_b),      32'(m_b));
            check($sformatf("rnd%0d result", c), 32'(rsp_result), 32'(m_res));
            check($sformatf("rnd%0d flags", c),  32'(rsp_flags),  32'(m_flg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit ADD unit among N_REQ requesting cores in the multiprocessor architecture.
- Captures the winning requester's operands and drives them to the shared adder.
- Registers the adder's result and status flags, then returns them to the winner through a valid/ack handshake.
- Sits between the per-core execute stages and the single ADD instance.

Parameters:
- N_REQ, 4, number of requesters (≥2). The index width is clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester add request.
- op_a  in  8*N_REQ  packed operand A; requester i uses bits [8i+7:8i].
- op_b  in  8*N_REQ  packed operand B; same packing as op_a.
- gnt  out  N_REQ  one-hot grant, high for exactly the EXEC cycle.
- add_a  out  8  operand A driven to the shared ADD.
- add_b  out  8  operand B driven to the shared ADD.
- add_result  in  8  result returned from the shared ADD (combinational).
- add_flags  in  4  ADD status: [0]=Z, [1]=S, [2]=C, [3]=V.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp_result  out  8  registered sum.
- rsp_flags  out  4  registered flags, same bit layout as add_flags.
- rsp_ack  in  N_REQ  per-requester response acknowledge.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt, rsp_valid, add_a, add_b, rsp_result, rsp_flags all 0; busy=0.
  - last_grant=N_REQ-1, so requester 0 has top priority first.
  - A reset arriving mid-operation abandons the transaction; no response is issued.
- State machine has three states: IDLE, EXEC, RESP.
- IDLE:
  - At the clock edge where any req bit is sampled high, choose the winner w by searching from (last_grant+1) mod N_REQ upward with wrap-around. last_grant has the lowest priority.
  - On that edge: add_a<=op_a[w], add_b<=op_b[w], gnt<=onehot(w), state<=EXEC.
  - With no req, state stays IDLE and all registers hold.
- EXEC (exactly 1 cycle):
  - add_a/add_b are stable and the adder settles combinationally.
  - At the end edge: rsp_result<=add_result, rsp_flags<=add_flags, rsp_valid<=onehot(w), gnt<=0, state<=RESP.
  - Operand changes or a dropped req during EXEC have no effect, because operands were captured on the grant edge.
- RESP:
  - rsp_valid, rsp_result and rsp_flags are held stable until rsp_ack[w] is sampled high.
  - On that edge: rsp_valid<=0, last_grant<=w, state<=IDLE.
  - rsp_ack bits of non-winning requesters are ignored. rsp_ack in any other state is ignored.
- Timing:
  - Latency from req sampled to rsp_valid high is 2 cycles.
  - Best-case throughput is one add per 3 cycles (ack in the first RESP cycle).
  - No new grant is issued while in EXEC or RESP.
- Requester obligations:
  - Hold req and operands stable until the cycle gnt is seen.
  - req still high in the IDLE cycle after ack counts as a new request. It competes at the lowest priority because last_grant=w.
- add_a/add_b hold their last captured values between operations and are not zeroed.
- Width rules:
  - The sum is the 8-bit modulo result from ADD; carry-out appears only in flag C.
  - The arbiter passes flags through unmodified.
- Simultaneous events:
  - A req arriving in the same edge as the ack returns to IDLE first; it is arbitrated on the following edge.
  - A single requester repeating back-to-back requests is always re-granted when no other req is pending.

Test Plan:
1. After reset, req=0001, op_a[0]=0x7F, op_b[0]=0x01 → gnt=0001 in cycle T+1; rsp_valid=0001 at T+2 with rsp_result=0x80, rsp_flags=4'b1010 (S, V); busy=1 from T+1 until ack.
2. req0 with 0xFF+0x01 → rsp_result=0x00, rsp_flags=4'b0101 (Z, C); ack → rsp_valid=0 and busy=0 the next cycle.
3. All four req high continuously and ack immediate → grants in order 0001, 0010, 0100, 1000, 0001; each requester gets its own operand sum; a new grant every 3 cycles.
4. Ack withheld 5 cycles, plus rsp_ack[2] pulsed while w=0 → rsp_valid=0001 and the result are held, no gnt, busy=1; the wrong-index ack is ignored; completion only on rsp_ack[0].
5. rst_n pulsed low during EXEC of requester 3 → all outputs 0 immediately, with no clock needed; no rsp_valid follows. Then req=0101 → requester 0 is granted.
6. req=0010 served, then req=1010 → requester 3 is granted before requester 1 is re-granted.
